sync_fifo_v2: RTL

Parametrised synchronous FIFO for buffering streams between datapath stages, clocked on `i_clk`. It generalises the team's basic FIFO with:
- a selectable read mode: registered-read or first-word fall-through (FWFT);
- an occupancy count and programmable almost-full/almost-empty flags;
- a synchronous flush;
- sticky overflow/underflow error flags;
- write acceptance on a full FIFO when a read is accepted in the same cycle.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_mem.sv | 27 ++
 rtl/sync_fifo_v2.sv | 109 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode constants and a constant-evaluable clog2.
// Reused by every FIFO variant in the codebase.
package fifo_pkg;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read, no reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int AW        = clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/sync_fifo_v2.sv
// Parametrised synchronous FIFO with registered or first-word fall-through read,
// occupancy count, almost flags, synchronous flush and sticky error flags.
module sync_fifo_v2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = FIFO_MODE_REG,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    localparam int AW        = clog2(DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_wen,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_ren,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_valid,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [CW-1:0]         o_count,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    logic [CW-1:0]         wptr;
    logic [CW-1:0]         rptr;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  flush;
    logic                  full;
    logic                  avail;
    logic                  rd;
    logic                  wr;

    assign flush = i_reset | i_clear;
    assign full  = (count == CW'(DEPTH));
    assign avail = (count != '0);
    // A read frees a slot in the same cycle, so a full FIFO may still accept a write.
    assign rd    = i_ren & avail;
    assign wr    = i_wen & (~full | rd);

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (wr & ~flush),
        .i_waddr (wptr[AW-1:0]),
        .i_wdata (i_wdata),
        .i_raddr (rptr[AW-1:0]),
        .o_rdata (mem_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (flush) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (wr) begin
                wptr <= wptr + CW'(1);
            end
            if (rd) begin
                rptr <= rptr + CW'(1);
            end
            count <= count + CW'(wr) - CW'(rd);
            if (i_wen & ~wr) begin
                o_overflow <= 1'b1;
            end
            if (i_ren & ~avail) begin
                o_underflow <= 1'b1;
            end
        end
    end

    assign o_count        = count;
    assign o_full         = full;
    assign o_empty        = ~avail;
    assign o_almost_full  = (count >= CW'(AF_LEVEL));
    assign o_almost_empty = (count <= CW'(AE_LEVEL));

    // FWFT presents the head word straight from the array, so the head slot stays
    // inside the DEPTH-word capacity instead of adding an extra output stage.
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        always_comb begin
            o_valid = avail;
            o_rdata = avail ? mem_rdata : '0;
        end
    end else begin : g_reg
        always_ff @(posedge i_clk) begin
            if (flush) begin
                o_valid <= 1'b0;
                o_rdata <= '0;
            end else begin
                o_valid <= rd;
                o_rdata <= rd ? mem_rdata : '0;
            end
        end
    end

endmodule
